// File: rtl/perips_intc.sv
// perips_intc: latches peripheral interrupt lines as pending bits and arbitrates them by fixed priority onto one core request, with claim/complete registers.
// Latency: pending is visible 1 cycle after the source; irq_o follows 1 cycle later; register reads return data 1 cycle after the strobe.
// Backpressure: none; the bus strobes are single-cycle and always accepted, and irq_o stays low while an ID is in service.
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module perips_intc #(
  parameter int NUM_IRQ = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [7:0]                 addr_i,
  input  logic                       data_rd_i,
  input  logic                       data_we_i,
  input  logic [`DATA_BUS_WIDTH-1:0] data_i,
  output logic [`DATA_BUS_WIDTH-1:0] data_o,
  input  logic [NUM_IRQ-1:0]         irq_src_i,
  output logic                       irq_o
);

  localparam int DW = `DATA_BUS_WIDTH;

  localparam logic [7:0] ADDR_IER      = 8'h00;
  localparam logic [7:0] ADDR_IPR      = 8'h04;
  localparam logic [7:0] ADDR_TRIG     = 8'h08;
  localparam logic [7:0] ADDR_CLAIM    = 8'h0C;
  localparam logic [7:0] ADDR_COMPLETE = 8'h10;
  localparam logic [7:0] ADDR_STATUS   = 8'h14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   ier_q, ier_d;
  logic [NUM_IRQ-1:0]   ipr_q, ipr_d;
  logic [NUM_IRQ-1:0]   trig_q, trig_d;
  logic [NUM_IRQ-1:0]   irq_src_q;
  logic [7:0]           active_id_q, active_id_d;
  logic [DW-1:0]        data_d;
  logic                 irq_d;

  logic [NUM_IRQ-1:0]   req;
  logic [NUM_IRQ-1:0]   win_oh;
  logic [7:0]           win_id;
  logic [NUM_IRQ-1:0]   irq_set;
  logic [NUM_IRQ-1:0]   irq_clr;
  logic                 claim_rd;
  logic                 claim_ok;
  logic                 complete_wr;
  logic                 unused_data;

  // Only the low data bits carry meaning for these registers.
  assign unused_data = ^data_i;

  assign req         = ipr_q & ier_q;
  assign claim_rd    = data_rd_i && (addr_i == ADDR_CLAIM);
  assign claim_ok    = claim_rd && (state_q == ST_ASSERT) && (|req);
  assign complete_wr = data_we_i && (addr_i == ADDR_COMPLETE);

  // Fixed priority: lowest index wins, so scan downwards and keep the last hit.
  always_comb begin
    win_oh = '0;
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_id    = 8'(i + 1);
      end
    end
  end

  // Pending update: new set requests override same-cycle software or claim clears.
  always_comb begin
    irq_set = (trig_q & irq_src_i & ~irq_src_q) | (~trig_q & irq_src_i);
    irq_clr = '0;
    if (data_we_i && (addr_i == ADDR_IPR)) irq_clr = irq_clr | data_i[NUM_IRQ-1:0];
    if (claim_ok)                          irq_clr = irq_clr | win_oh;
    ipr_d  = (ipr_q & ~irq_clr) | irq_set;
    ier_d  = (data_we_i && (addr_i == ADDR_IER))  ? data_i[NUM_IRQ-1:0] : ier_q;
    trig_d = (data_we_i && (addr_i == ADDR_TRIG)) ? data_i[NUM_IRQ-1:0] : trig_q;
  end

  // Read mux samples pre-write register values; data_o holds when not reading.
  always_comb begin
    data_d = data_o;
    if (data_rd_i) begin
      data_d = '0;
      case (addr_i)
        ADDR_IER:    data_d[NUM_IRQ-1:0] = ier_q;
        ADDR_IPR:    data_d[NUM_IRQ-1:0] = ipr_q;
        ADDR_TRIG:   data_d[NUM_IRQ-1:0] = trig_q;
        ADDR_CLAIM:  if (claim_ok) data_d[7:0] = win_id;
        ADDR_STATUS: begin
          data_d[15:8] = active_id_q;
          data_d[1:0]  = state_q;
        end
        default:     data_d = '0;
      endcase
    end
  end

  // Service FSM next state; irq_o is registered straight from the ASSERT state.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!(|req)) begin
          state_d = ST_IDLE;
        end else if (claim_ok) begin
          state_d     = ST_SERVICE;
          active_id_d = win_id;
        end
      end
      ST_SERVICE: begin
        if (complete_wr && (data_i[7:0] == active_id_q)) begin
          state_d     = ST_IDLE;
          active_id_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d = (state_d == ST_ASSERT);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Register file, source history and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ier_q       <= '0;
      ipr_q       <= '0;
      trig_q      <= '0;
      irq_src_q   <= '0;
      active_id_q <= '0;
      data_o      <= '0;
      irq_o       <= 1'b0;
    end else begin
      ier_q       <= ier_d;
      ipr_q       <= ipr_d;
      trig_q      <= trig_d;
      irq_src_q   <= irq_src_i;
      active_id_q <= active_id_d;
      data_o      <= data_d;
      irq_o       <= irq_d;
    end
  end

endmodule

// File: tb/tb_perips_intc.sv
// tb_perips_intc: directed bench for perips_intc with a read-data scoreboard.
// Reads push their expected data into a queue; a monitor pops and compares one cycle after each strobe.
// irq_o and reset values are compared directly at the falling edge.
module tb_perips_intc;

  localparam logic [7:0] A_IER = 8'h00, A_IPR = 8'h04, A_TRIG = 8'h08;
  localparam logic [7:0] A_CLAIM = 8'h0C, A_COMPLETE = 8'h10, A_STATUS = 8'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr = '0;
  logic        rd = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  src = '0;
  logic        irq;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen = 1'b0;

  perips_intc #(.NUM_IRQ(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .addr_i    (addr),
    .data_rd_i (rd),
    .data_we_i (we),
    .data_i    (wdata),
    .data_o    (rdata),
    .irq_src_i (src),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Remember which edges carried a read so the monitor knows when data_o is due.
  always @(posedge clk) rd_seen <= rd && !rst;

  // Monitor: data_o is valid the cycle after a read strobe.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", rdata);
      end else begin
        check(name_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_exp(input logic [7:0] a, input logic [31:0] e, input string name);
    exp_q.push_back(e); name_q.push_back(name);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic rdwr(input logic [7:0] a, input logic [31:0] d, input logic [31:0] e, input string name);
    exp_q.push_back(e); name_q.push_back(name);
    addr = a; wdata = d; rd = 1'b1; we = 1'b1;
    @(negedge clk);
    rd = 1'b0; we = 1'b0;
  endtask

  initial begin
    // 1: reset with all sources high; level mode sets every pending bit afterwards.
    src = 8'hFF;
    idle(3);
    check("rst_irq_o", {31'b0, irq}, 32'h0);
    check("rst_data_o", rdata, 32'h0);
    rst = 1'b0;
    idle(1);
    rd_exp(A_IPR, 32'hFF, "ipr_after_reset");
    check("irq_o_ier_zero", {31'b0, irq}, 32'h0);
    src = 8'h00;
    wr(A_IPR, 32'hFF);
    rd_exp(A_IPR, 32'h00, "ipr_cleared");

    // 2: single edge-mode pulse on source 0, claim and complete.
    wr(A_IER, 32'h01);
    wr(A_TRIG, 32'h01);
    src = 8'h01;
    idle(1);
    src = 8'h00;
    check("irq_o_not_yet", {31'b0, irq}, 32'h0);
    rd_exp(A_IPR, 32'h01, "ipr_edge_set");
    check("irq_o_assert", {31'b0, irq}, 32'h1);
    rd_exp(A_CLAIM, 32'h1, "claim_id1");
    check("irq_o_after_claim", {31'b0, irq}, 32'h0);
    rd_exp(A_STATUS, 32'h0102, "status_service1");
    rd_exp(A_IPR, 32'h00, "ipr_after_claim");
    wr(A_COMPLETE, 32'h1);
    rd_exp(A_STATUS, 32'h0000, "status_idle");

    // 3: level sources 5 and 2 together; lower index wins.
    wr(A_IER, 32'hFF);
    wr(A_TRIG, 32'h00);
    src = 8'h24;
    idle(2);
    rd_exp(A_CLAIM, 32'h3, "claim_id3");
    check("irq_o_service", {31'b0, irq}, 32'h0);

    // 4: in service, wrong COMPLETE, CLAIM and new pending are all ignored.
    wr(A_COMPLETE, 32'h4);
    rd_exp(A_STATUS, 32'h0302, "status_wrong_complete");
    rd_exp(A_CLAIM, 32'h0, "claim_in_service");
    src = 8'h25;
    idle(2);
    check("irq_o_no_nesting", {31'b0, irq}, 32'h0);
    src = 8'h24;
    wr(A_IPR, 32'h01);
    rd_exp(A_IPR, 32'h24, "ipr_level_reset_by_src");
    src = 8'h20;
    wr(A_IPR, 32'h04);
    wr(A_COMPLETE, 32'h3);
    check("irq_o_after_complete", {31'b0, irq}, 32'h0);
    idle(1);
    check("irq_o_reassert", {31'b0, irq}, 32'h1);
    rd_exp(A_CLAIM, 32'h6, "claim_id6");
    wr(A_COMPLETE, 32'h6);

    // 5: disabling in ASSERT drops irq_o, keeps IPR; edge set beats write-1 clear.
    idle(1);
    check("irq_o_level_again", {31'b0, irq}, 32'h1);
    wr(A_IER, 32'h00);
    idle(1);
    check("irq_o_ier_cleared", {31'b0, irq}, 32'h0);
    rd_exp(A_STATUS, 32'h0000, "status_back_idle");
    rd_exp(A_IPR, 32'h20, "ipr_unchanged");
    wr(A_TRIG, 32'h02);
    src = 8'h22;
    wr(A_IPR, 32'h02);
    src = 8'h20;
    rd_exp(A_IPR, 32'h22, "ipr_set_wins");

    // Read during write sees old value; writes mask to NUM_IRQ; unmapped and COMPLETE read 0.
    rdwr(A_IER, 32'h0F, 32'h00, "rdwr_old_ier");
    rd_exp(A_IER, 32'h0F, "ier_new");
    wr(A_IER, 32'hFFFF_FFFF);
    rd_exp(A_IER, 32'hFF, "ier_masked");
    rd_exp(8'h18, 32'h0, "unmapped_read");
    rd_exp(A_COMPLETE, 32'h0, "complete_read");

    // 6: reset in service clears everything.
    rd_exp(A_CLAIM, 32'h2, "claim_id2");
    rd_exp(A_STATUS, 32'h0202, "status_service2");
    rst = 1'b1;
    src = 8'h00;
    idle(1);
    check("rst_svc_irq_o", {31'b0, irq}, 32'h0);
    check("rst_svc_data_o", rdata, 32'h0);
    rst = 1'b0;
    rd_exp(A_STATUS, 32'h0, "status_after_reset");
    rd_exp(A_IPR, 32'h0, "ipr_after_reset2");
    rd_exp(A_IER, 32'h0, "ier_after_reset");

    idle(3);
    while (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL missing_read %s: got no data, expected 0x%08h", name_q.pop_front(), exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
